// File: rtl/axis_packet_arbiter_pkg.sv
// Shared types for the packet-granular AXI-Stream arbiter.
package axis_arb_pkg;

    typedef enum logic {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_t;

    localparam int PKT_CNT_W = 32;

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// AXI-Stream bundle of LANES parallel channels; LANES=NUM_INPUTS on the
// requester side, LANES=1 towards the mesh injection port.
interface axis_packet_arbiter_if #(
    parameter int LANES       = 1,
    parameter int TDATA_WIDTH = 512,
    parameter int TDEST_WIDTH = 4
);
    logic [LANES-1:0]                  tvalid;
    logic [LANES-1:0]                  tready;
    logic [LANES-1:0]                  tlast;
    logic [LANES-1:0][TDATA_WIDTH-1:0] tdata;
    logic [LANES-1:0][TDEST_WIDTH-1:0] tdest;

    modport master (output tvalid, tdata, tlast, tdest, input tready);
    modport slave  (input tvalid, tdata, tlast, tdest, output tready);
endinterface

// File: rtl/axis_packet_arbiter_skid_buffer.sv
// Two-entry skid buffer with registered outputs; only compiled when
// AXIS_ARB_OUTPUT_REG_EN is defined (the arbiter is its sole user).
`ifdef AXIS_ARB_OUTPUT_REG_EN
module axis_skid_buffer #(
    parameter int DATA_WIDTH = 517
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);
    logic                  skid_valid;
    logic [DATA_WIDTH-1:0] skid_data;

    // Ready depends only on a flop, so upstream never sees a comb path from m_ready.
    assign s_ready = ~skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid    <= 1'b0;
            m_data     <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (m_ready || !m_valid) begin
            if (skid_valid) begin
                m_valid    <= 1'b1;
                m_data     <= skid_data;
                skid_valid <= 1'b0;
            end else begin
                m_valid <= s_valid;
                m_data  <= s_data;
            end
        end else if (s_valid && s_ready) begin
            skid_valid <= 1'b1;
            skid_data  <= s_data;
        end
    end
endmodule
`endif

// File: rtl/axis_packet_arbiter.sv
// N-to-1 round-robin AXI-Stream arbiter, packet granular, for a mesh injection port.
// Define AXIS_ARB_OUTPUT_REG_EN to register the m side through a skid buffer.
//
// state      | meaning
// ARB_IDLE   | no owner; m side idle, all requesters held off, scanning for a winner
// ARB_LOCKED | grant_idx owns the port until its tlast beat is accepted
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_INPUTS  = 4,
    parameter  int TDATA_WIDTH = 512,
    parameter  int TDEST_WIDTH = 4,
    localparam int GRANT_W     = $clog2(NUM_INPUTS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    axis_packet_arbiter_if.slave  s_axis,
    axis_packet_arbiter_if.master m_axis,
    output logic [GRANT_W-1:0]   grant_idx,
    output logic [PKT_CNT_W-1:0] pkt_count
);
    arb_state_t             state, state_nxt;
    logic [GRANT_W-1:0]     rr_ptr, rr_ptr_nxt, grant_nxt;
    logic [GRANT_W-1:0]     winner, scan_idx;
    logic                   found;
    logic                   pkt_done;

    logic                   core_valid, core_ready, core_last;
    logic [TDATA_WIDTH-1:0] core_data;
    logic [TDEST_WIDTH-1:0] core_dest;

    always_comb begin
        winner   = '0;
        found    = 1'b0;
        scan_idx = '0;
        for (int k = 0; k < NUM_INPUTS; k++) begin
            scan_idx = GRANT_W'((int'(rr_ptr) + k) % NUM_INPUTS);
            if (!found && s_axis.tvalid[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_ptr_nxt    = rr_ptr;
        grant_nxt     = grant_idx;
        pkt_done      = 1'b0;
        s_axis.tready = '0;
        core_valid    = 1'b0;
        core_data     = s_axis.tdata[grant_idx];
        core_last     = s_axis.tlast[grant_idx];
        core_dest     = s_axis.tdest[grant_idx];
        if (state == ARB_IDLE) begin
            if (found) begin
                state_nxt  = ARB_LOCKED;
                grant_nxt  = winner;
                rr_ptr_nxt = (int'(winner) == NUM_INPUTS - 1) ? '0 : winner + 1'b1;
            end
        end else begin
            core_valid               = s_axis.tvalid[grant_idx];
            s_axis.tready[grant_idx] = core_ready;
            if (core_valid && core_ready && core_last) begin
                state_nxt = ARB_IDLE;
                pkt_done  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ARB_IDLE;
            rr_ptr    <= '0;
            grant_idx <= '0;
            pkt_count <= '0;
        end else begin
            state     <= state_nxt;
            rr_ptr    <= rr_ptr_nxt;
            grant_idx <= grant_nxt;
            if (pkt_done) begin
                pkt_count <= pkt_count + PKT_CNT_W'(1);
            end
        end
    end

`ifdef AXIS_ARB_OUTPUT_REG_EN
    logic [TDATA_WIDTH+TDEST_WIDTH:0] skid_out;

    // pkt_count then counts packets entering the buffer, not leaving it.
    axis_skid_buffer #(
        .DATA_WIDTH (TDATA_WIDTH + TDEST_WIDTH + 1)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (core_valid),
        .s_ready (core_ready),
        .s_data  ({core_last, core_dest, core_data}),
        .m_valid (m_axis.tvalid[0]),
        .m_ready (m_axis.tready[0]),
        .m_data  (skid_out)
    );

    assign m_axis.tlast[0] = skid_out[TDATA_WIDTH+TDEST_WIDTH];
    assign m_axis.tdest[0] = skid_out[TDATA_WIDTH +: TDEST_WIDTH];
    assign m_axis.tdata[0] = skid_out[TDATA_WIDTH-1:0];
`else
    assign m_axis.tvalid[0] = core_valid;
    assign m_axis.tdata[0]  = core_data;
    assign m_axis.tlast[0]  = core_last;
    assign m_axis.tdest[0]  = core_dest;
    assign core_ready       = m_axis.tready[0];
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Bench for axis_packet_arbiter (default build): directed scenarios plus
// randomized traffic, all checked against an owner/rotation reference model.
module tb_axis_packet_arbiter;
    localparam int NI    = 4;
    localparam int DW    = 512;
    localparam int DESTW = 4;

    typedef struct {
        logic [DW-1:0]    data;
        logic             last;
        logic [DESTW-1:0] dest;
        int               gap;
    } beat_t;

    logic clk;
    logic rst_n;
    logic [1:0]  grant_idx;
    logic [31:0] pkt_count;

    axis_packet_arbiter_if #(.LANES(NI), .TDATA_WIDTH(DW), .TDEST_WIDTH(DESTW)) s_if ();
    axis_packet_arbiter_if #(.LANES(1),  .TDATA_WIDTH(DW), .TDEST_WIDTH(DESTW)) m_if ();

    axis_packet_arbiter #(.NUM_INPUTS(NI), .TDATA_WIDTH(DW), .TDEST_WIDTH(DESTW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_axis    (s_if),
        .m_axis    (m_if),
        .grant_idx (grant_idx),
        .pkt_count (pkt_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;

    // stimulus state (initial block only)
    beat_t pend[NI][$];
    int    hold[NI];
    int    pres_pct = 100;
    bit    rnd_ready = 0;

    // model / monitor state (compare process only)
    bit          acc[NI];
    int          owner = -1;
    int          ptr = 0;
    int          last_grant = 0;
    logic [31:0] cnt = '0;
    int          cyc = 0;
    int          glog[$];
    int          gcyc[$];
    logic [16:0] mlog[$];

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [NI-1:0] tr;
        logic          ev;
        int            w;
        if (!rst_n) begin
            owner = -1; ptr = 0; last_grant = 0; cnt = '0;
            for (int i = 0; i < NI; i++) acc[i] = 1'b0;
        end else begin
            ev = (owner >= 0) ? s_if.tvalid[owner] : 1'b0;
            tr = '0;
            if (owner >= 0) tr[owner] = m_if.tready[0];
            check("m_tvalid", DW'(m_if.tvalid[0]), DW'(ev));
            check("s_tready", DW'(s_if.tready), DW'(tr));
            check("grant_idx", DW'(grant_idx), DW'(last_grant));
            check("pkt_count", DW'(pkt_count), DW'(cnt));
            if (ev) begin
                check("m_tdata", m_if.tdata[0], s_if.tdata[owner]);
                check("m_tlast", DW'(m_if.tlast[0]), DW'(s_if.tlast[owner]));
                check("m_tdest", DW'(m_if.tdest[0]), DW'(s_if.tdest[owner]));
            end
            for (int i = 0; i < NI; i++) acc[i] = s_if.tvalid[i] & s_if.tready[i];
            if (m_if.tvalid[0] && m_if.tready[0])
                mlog.push_back({m_if.tlast[0], m_if.tdata[0][15:0]});
            if (owner < 0) begin
                w = -1;
                for (int k = 0; k < NI; k++)
                    if (w < 0 && s_if.tvalid[(ptr + k) % NI]) w = (ptr + k) % NI;
                if (w >= 0) begin
                    owner = w; last_grant = w; ptr = (w + 1) % NI;
                end
            end else if (ev && m_if.tready[0] && s_if.tlast[owner]) begin
                glog.push_back(owner);
                gcyc.push_back(cyc);
                cnt = cnt + 1;
                owner = -1;
            end
            cyc++;
        end
    end

    function automatic beat_t mk(int i, int b, int nb, logic [DESTW-1:0] dest, int gap);
        beat_t r;
        for (int w2 = 0; w2 < DW / 32; w2++) r.data[32*w2 +: 32] = $urandom;
        r.data[15:0] = {8'(i), 8'(b)};
        r.last = (b == nb - 1);
        r.dest = dest;
        r.gap  = gap;
        return r;
    endfunction

    task automatic push_pkt(int i, int nb, logic [DESTW-1:0] dest, int gap0);
        for (int b = 0; b < nb; b++) pend[i].push_back(mk(i, b, nb, dest, (b == 0) ? gap0 : 0));
    endtask

    task automatic drive();
        for (int i = 0; i < NI; i++) begin
            if (acc[i] && pend[i].size() > 0) begin
                hold[i] = pend[i][0].gap;
                void'(pend[i].pop_front());
                s_if.tvalid[i] = 1'b0;
            end
            if (!s_if.tvalid[i]) begin
                if (hold[i] > 0) hold[i]--;
                else if (pend[i].size() > 0 && $urandom_range(99) < pres_pct) begin
                    s_if.tvalid[i] = 1'b1;
                    s_if.tdata[i]  = pend[i][0].data;
                    s_if.tlast[i]  = pend[i][0].last;
                    s_if.tdest[i]  = pend[i][0].dest;
                end
            end
        end
        if (rnd_ready) m_if.tready[0] = ($urandom_range(99) < 75);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic clear_stim();
        for (int i = 0; i < NI; i++) begin
            pend[i].delete();
            hold[i] = 0;
        end
        s_if.tvalid = '0; s_if.tlast = '0; s_if.tdata = '0; s_if.tdest = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_stim();
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run_until(int n, int budget);
        int k = 0;
        while (glog.size() < n && k < budget) begin
            tick();
            k++;
        end
        tests++;
        if (glog.size() < n) begin
            fails++;
            $display("FAIL timeout: %0d packets seen, %0d required", glog.size(), n);
        end
    endtask

    int gb, mb, total, k;

    initial begin
        rst_n = 1'b0;
        m_if.tready = 1'b1;
        clear_stim();

        // 1: reset, with requests already pending
        s_if.tvalid = '1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_m_tvalid", DW'(m_if.tvalid[0]), '0);
        check("rst_s_tready", DW'(s_if.tready), '0);
        check("rst_pkt_count", DW'(pkt_count), '0);
        check("rst_grant_idx", DW'(grant_idx), '0);
        do_reset();

        // 2: single 3-beat packet from input 2
        gb = glog.size(); mb = mlog.size();
        push_pkt(2, 3, 4'h1, 0);
        run_until(gb + 1, 50);
        check("t2_grant", DW'(grant_idx), DW'(2));
        check("t2_count", DW'(pkt_count), DW'(1));
        check("t2_beats", DW'(mlog.size() - mb), DW'(3));
        if (mlog.size() >= mb + 3) begin
            check("t2_beat0", DW'(mlog[mb]),     DW'(17'h00200));
            check("t2_beat1", DW'(mlog[mb + 1]), DW'(17'h00201));
            check("t2_beat2", DW'(mlog[mb + 2]), DW'(17'h10202));
        end

        // 3: all inputs request single-beat packets
        do_reset();
        gb = glog.size();
        push_pkt(0, 1, 4'h3, 0); push_pkt(0, 1, 4'h7, 0);
        push_pkt(1, 1, 4'h5, 0); push_pkt(2, 1, 4'h9, 0); push_pkt(3, 1, 4'hc, 0);
        run_until(gb + 4, 60);
        check("t3_count4", DW'(pkt_count), DW'(4));
        run_until(gb + 5, 60);
        if (glog.size() >= gb + 5) begin
            for (int j = 0; j < 5; j++) check("t3_order", DW'(glog[gb + j]), DW'(j % 4));
            for (int j = 0; j < 4; j++) check("t3_bubble", DW'(gcyc[gb + j + 1] - gcyc[gb + j]), DW'(2));
        end

        // 4: input 1 owns while 0 and 3 wait; ready toggles
        do_reset();
        gb = glog.size();
        push_pkt(1, 3, 4'h2, 0);
        tick(); tick();
        push_pkt(0, 1, 4'h4, 0); push_pkt(3, 1, 4'h6, 0);
        k = 0;
        while (glog.size() < gb + 1 && k < 40) begin
            tick();
            m_if.tready = (k % 2 == 0);
            k++;
        end
        m_if.tready = 1'b1;
        run_until(gb + 3, 60);
        if (glog.size() >= gb + 3) begin
            check("t4_first", DW'(glog[gb]), DW'(1));
            check("t4_next", DW'(glog[gb + 1]), DW'(3));
            check("t4_last", DW'(glog[gb + 2]), DW'(0));
        end

        // 5: owner 2 pauses 5 cycles after its first beat while 0 requests
        do_reset();
        gb = glog.size();
        pend[2].push_back(mk(2, 0, 4, 4'h8, 5));
        for (int b = 1; b < 4; b++) pend[2].push_back(mk(2, b, 4, 4'h8, 0));
        tick(); tick();
        push_pkt(0, 1, 4'h1, 0);
        repeat (4) tick();
        check("t5_grant_held", DW'(grant_idx), DW'(2));
        check("t5_gap_valid", DW'(s_if.tvalid[2]), DW'(0));
        run_until(gb + 2, 60);
        if (glog.size() >= gb + 2) begin
            check("t5_first", DW'(glog[gb]), DW'(2));
            check("t5_second", DW'(glog[gb + 1]), DW'(0));
        end
        check("t5_count", DW'(pkt_count), DW'(2));

        // 6: reset pulse mid-packet
        push_pkt(1, 3, 4'ha, 0);
        k = 0;
        while (pend[1].size() > 2 && k < 20) begin
            tick();
            k++;
        end
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_tvalid", DW'(m_if.tvalid[0]), '0);
        check("t6_count_clr", DW'(pkt_count), '0);
        clear_stim();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        gb = glog.size();
        push_pkt(1, 1, 4'h0, 0); push_pkt(3, 1, 4'h0, 0);
        run_until(gb + 2, 40);
        if (glog.size() >= gb + 2) begin
            check("t6_rr_restart", DW'(glog[gb]), DW'(1));
            check("t6_rr_next", DW'(glog[gb + 1]), DW'(3));
        end

        // random traffic
        gb = glog.size();
        total = 0;
        pres_pct = 70;
        rnd_ready = 1;
        for (int i = 0; i < NI; i++)
            for (int p = 0; p < 30; p++) begin
                int nb;
                nb = $urandom_range(1, 4);
                for (int b = 0; b < nb; b++)
                    pend[i].push_back(mk(i, b, nb, DESTW'($urandom), $urandom_range(0, 2)));
                total++;
            end
        run_until(gb + total, 20000);
        check("rnd_total", DW'(glog.size() - gb), DW'(total));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
